dual_buf_ctrl: RTL and testbench
================================

Name: dual_buf_ctrl

Overview:
Sequencer for the dual-phase RF shift buffer. It generates the two sampling strobes (sh_en1, sh_en2), half a bit period apart, from a free-running bit-phase counter. It detects the buffer's packet-received flag and captures the 64-bit word, then hands it to the downstream consumer over a valid/ready handshake. After each delivered packet it clears the buffer and re-arms scanning.

Parameters:
BIT_PERIOD, 10000, clk cycles per RF bit (1 ms at 100 ns clk); must be >= 4.
PHASE_OFFSET, 5000, cycle index within the bit period at which sh_en1 fires; must satisfy 0 < PHASE_OFFSET < BIT_PERIOD.
CLR_CYCLES, 2, buf_clr pulse length in cycles; must be >= 1.
DATA_W, 64, packet width.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
en  in  1  enable scanning
sh_en1  out  1  late-phase shift strobe to buffer, one cycle wide
sh_en2  out  1  early-phase shift strobe to buffer, one cycle wide
buf_clr  out  1  buffer clear
buf_dout  in  DATA_W  buffer contents
buf_pkt_rec  in  1  buffer packet-received flag (level)
pkt_data  out  DATA_W  captured packet
pkt_phase  out  1  strobe preceding capture: 0 = sh_en2, 1 = sh_en1
pkt_valid  out  1  packet available
pkt_ready  in  1  consumer accepts
pkt_cnt  out  16  accepted packets, wraps
drop_cnt  out  8  packets missed while delivering, saturates at 255

Behaviour:
- Reset, including mid-operation: state IDLE, phase counter 0, last-phase register 0, pkt_rec edge register 0. All outputs are 0 (sh_en1, sh_en2, buf_clr, pkt_data, pkt_phase, pkt_valid, pkt_cnt, drop_cnt).
- States: IDLE, FLUSH, SCAN, DELIVER.
- IDLE: strobes off. If en=1, go to FLUSH.
- FLUSH: buf_clr=1 for exactly CLR_CYCLES cycles; strobes off. Then go to SCAN with the phase counter loaded to 0.
- Phase counter (SCAN and DELIVER only):
  - counts 0..BIT_PERIOD-1 and wraps;
  - sh_en2=1 in the cycle cnt==0; sh_en1=1 in the cycle cnt==PHASE_OFFSET;
  - strobes are registered outputs, never both high in one cycle;
  - the last-phase register records which strobe fired most recently.
- The first sh_en2 occurs in the first SCAN cycle.
- Edge detect: rise = buf_pkt_rec & ~buf_pkt_rec_q.
- SCAN:
  - On rise, in the same edge, pkt_data<=buf_dout and pkt_phase<=last-phase; next cycle pkt_valid=1, state DELIVER.
  - A rise takes precedence over en=0 in the same cycle.
  - Otherwise en=0 returns to IDLE next cycle.
- DELIVER:
  - pkt_data, pkt_phase and pkt_valid are held stable until pkt_valid&pkt_ready.
  - Strobes keep running.
  - Any rise increments drop_cnt, saturating.
  - On handshake: pkt_valid=0 next cycle, pkt_cnt+1, then FLUSH if en=1, else IDLE (IDLE also passes through FLUSH first).
  - en=0 never aborts a pending delivery.
- A rise in the same cycle as a handshake counts as a drop.
- Latency: rise at cycle N, pkt_valid high at N+1. Handshake at M: buf_clr high at M+1..M+CLR_CYCLES, first sh_en2 at M+CLR_CYCLES+1.
- A strobe compare hit coinciding with the capture cycle is still emitted.

Decomposition:
- Shared package dual_buf_pkg:
  - state enum (IDLE/FLUSH/SCAN/DELIVER);
  - DATA_W default;
  - PKT_CNT_W=16 and DROP_CNT_W=8;
  - PHASE_EARLY=0 and PHASE_LATE=1 constants.
- One sub-module, dual_buf_strobe_gen:
  - phase counter, both strobes and the last-phase register;
  - inputs clk, rst, run, restart.
- The top level keeps the FSM, capture, edge detect and counters.

Test Plan:
Bench runs with BIT_PERIOD=10, PHASE_OFFSET=5, CLR_CYCLES=2.
1. rst 2 cycles, en=1 at cycle 3 -> buf_clr high cycles 4-5; sh_en2 at 6, 16, 26; sh_en1 at 11, 21; never both high.
2. In SCAN, buf_dout=64'hA5A5_0F0F_1234_5678 and buf_pkt_rec rises at cycle 13 -> pkt_valid at 14, pkt_data equals that word, pkt_phase=1; with pkt_ready=1 at 14, pkt_cnt=1 and buf_clr at 15-16.
3. Hold pkt_ready=0 for 40 cycles while buf_pkt_rec toggles 3 times -> pkt_data stable, drop_cnt=3; ready then gives a single accept.
4. 300 rises during a stalled DELIVER -> drop_cnt saturates at 255.
5. en=0 in the same cycle as a rise -> capture still occurs; after handshake, buf_clr pulses, then IDLE with strobes silent.
6. rst asserted during DELIVER with pkt_valid=1 -> next cycle all outputs 0 and IDLE; re-enable repeats scenario 1 timing.

Source files
------------

// File: rtl/dual_buf_pkg.sv
// Shared types and constants for the dual-phase RF shift buffer sequencer.
package dual_buf_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int PKT_CNT_W  = 16;
  localparam int DROP_CNT_W = 8;

  // Which strobe fired most recently: early (sh_en2) or late (sh_en1)
  localparam logic PHASE_EARLY = 1'b0;
  localparam logic PHASE_LATE  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLUSH   = 2'd1,
    SCAN    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  // Saturating increment for the drop counter
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dual_buf_strobe_gen.sv
// Free-running bit-phase counter producing the two registered shift strobes
// half a bit apart, plus a record of which strobe fired last.
module dual_buf_strobe_gen
  import dual_buf_pkg::*;
#(
  parameter int BIT_PERIOD   = 10000,
  parameter int PHASE_OFFSET = 5000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic sh_en1,
  output logic sh_en2,
  output logic last_phase
);

  localparam int              CNT_W    = $clog2(BIT_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_LATE = CNT_W'(PHASE_OFFSET);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Wrapping successor of the phase counter
  always_comb begin
    cnt_next = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
  end

  // Strobes are decoded from the next count so they line up with the count value
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      sh_en1     <= 1'b0;
      sh_en2     <= 1'b0;
      last_phase <= PHASE_EARLY;
    end else if (restart) begin
      cnt        <= '0;
      sh_en2     <= 1'b1;
      sh_en1     <= 1'b0;
      last_phase <= PHASE_EARLY;
    end else if (run) begin
      cnt    <= cnt_next;
      sh_en2 <= (cnt_next == '0);
      sh_en1 <= (cnt_next == CNT_LATE);
      if (cnt_next == '0) begin
        last_phase <= PHASE_EARLY;
      end else if (cnt_next == CNT_LATE) begin
        last_phase <= PHASE_LATE;
      end
    end else begin
      cnt    <= '0;
      sh_en1 <= 1'b0;
      sh_en2 <= 1'b0;
    end
  end

endmodule

// File: rtl/dual_buf_ctrl.sv
// Sequencer for the dual-phase RF shift buffer: flushes the buffer, runs the
// sampling strobes, captures received packets and hands them downstream.
module dual_buf_ctrl
  import dual_buf_pkg::*;
#(
  parameter int BIT_PERIOD   = 10000,
  parameter int PHASE_OFFSET = 5000,
  parameter int CLR_CYCLES   = 2,
  parameter int DATA_W       = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  sh_en1,
  output logic                  sh_en2,
  output logic                  buf_clr,
  input  logic [DATA_W-1:0]     buf_dout,
  input  logic                  buf_pkt_rec,
  output logic [DATA_W-1:0]     pkt_data,
  output logic                  pkt_phase,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic [PKT_CNT_W-1:0]  pkt_cnt,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int               CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic [CLR_W-1:0] clr_cnt;
  logic             rec_q;
  logic             rise;
  logic             handshake;
  logic             last_phase;
  logic             run;
  logic             restart;

  assign rise      = buf_pkt_rec & ~rec_q;
  assign handshake = (state == DELIVER) & pkt_ready;
  assign pkt_valid = (state == DELIVER);
  assign buf_clr   = (state == FLUSH);

  dual_buf_strobe_gen #(
    .BIT_PERIOD  (BIT_PERIOD),
    .PHASE_OFFSET(PHASE_OFFSET)
  ) u_strobe (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .restart   (restart),
    .sh_en1    (sh_en1),
    .sh_en2    (sh_en2),
    .last_phase(last_phase)
  );

  // Next-state logic; a flush always precedes both scanning and going idle
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (en) state_next = FLUSH;
      end
      FLUSH: begin
        if (clr_cnt == CLR_LAST) state_next = en ? SCAN : IDLE;
      end
      SCAN: begin
        if (rise) begin
          state_next = DELIVER;
        end else if (!en) begin
          state_next = IDLE;
        end
      end
      DELIVER: begin
        if (pkt_ready) state_next = FLUSH;
      end
      default: state_next = IDLE;
    endcase
    restart = (state == FLUSH) && (state_next == SCAN);
    run     = (state_next == SCAN) || (state_next == DELIVER);
  end

  // State register, flush length counter and packet-flag edge register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      clr_cnt <= '0;
      rec_q   <= 1'b0;
    end else begin
      state   <= state_next;
      rec_q   <= buf_pkt_rec;
      clr_cnt <= ((state == FLUSH) && (state_next == FLUSH)) ? clr_cnt + 1'b1 : '0;
    end
  end

  // Packet capture plus accepted and dropped packet counters
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_data  <= '0;
      pkt_phase <= PHASE_EARLY;
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
    end else begin
      if ((state == SCAN) && rise) begin
        pkt_data  <= buf_dout;
        pkt_phase <= last_phase;
      end
      if ((state == DELIVER) && rise) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
      if (handshake) begin
        pkt_cnt <= pkt_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dual_buf_ctrl.sv
// Self-checking bench for dual_buf_ctrl with a bit period of 10 cycles.
module tb_dual_buf_ctrl;

  localparam int BP  = 10;
  localparam int PO  = 5;
  localparam int CLR = 2;
  localparam int DW  = 64;

  localparam logic [DW-1:0] WORD_A = 64'hA5A5_0F0F_1234_5678;
  localparam logic [DW-1:0] WORD_B = 64'h0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] WORD_C = 64'hFEDC_BA98_7654_3210;
  localparam logic [DW-1:0] WORD_D = 64'h5555_AAAA_3333_CCCC;
  localparam logic [DW-1:0] WORD_E = 64'h0F1E_2D3C_4B5A_6978;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sh_en1;
  logic          sh_en2;
  logic          buf_clr;
  logic [DW-1:0] buf_dout;
  logic          buf_pkt_rec;
  logic [DW-1:0] pkt_data;
  logic          pkt_phase;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [15:0]   pkt_cnt;
  logic [7:0]    drop_cnt;

  int tests = 0;
  int fails = 0;
  int cyc   = 1;

  // Reference model state, described in terms of time rather than FSM encoding
  logic          m_scanning = 1'b0;
  logic          m_valid    = 1'b0;
  logic          m_phase    = 1'b0;
  logic [DW-1:0] m_data     = '0;
  logic          m_prev_rec = 1'b0;
  int            m_flush_left = 0;
  int            m_origin   = 0;
  int            m_pkt_cnt  = 0;
  int            m_drop     = 0;
  logic          model_ok   = 1'b0;

  always #5 clk = ~clk;

  dual_buf_ctrl #(
    .BIT_PERIOD  (BP),
    .PHASE_OFFSET(PO),
    .CLR_CYCLES  (CLR),
    .DATA_W      (DW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sh_en1     (sh_en1),
    .sh_en2     (sh_en2),
    .buf_clr    (buf_clr),
    .buf_dout   (buf_dout),
    .buf_pkt_rec(buf_pkt_rec),
    .pkt_data   (pkt_data),
    .pkt_phase  (pkt_phase),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_cnt    (pkt_cnt),
    .drop_cnt   (drop_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: actual %0h expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic rec,
                               input logic [DW-1:0] d, input logic rdy);
    rst         = r;
    en          = e;
    buf_pkt_rec = rec;
    buf_dout    = d;
    pkt_ready   = rdy;
    @(posedge clk);
    #1;
  endtask

  // Model update: consume this cycle's inputs and advance to the next cycle
  always @(posedge clk) begin
    int  pos;
    logic rise;
    if (rst) begin
      m_scanning   = 1'b0;
      m_valid      = 1'b0;
      m_phase      = 1'b0;
      m_data       = '0;
      m_prev_rec   = 1'b0;
      m_flush_left = 0;
      m_origin     = 0;
      m_pkt_cnt    = 0;
      m_drop       = 0;
    end else begin
      rise = buf_pkt_rec && !m_prev_rec;
      pos  = (cyc - m_origin) % BP;
      if (m_valid) begin
        if (rise && m_drop < 255) m_drop++;
        if (pkt_ready) begin
          m_valid      = 1'b0;
          m_scanning   = 1'b0;
          m_pkt_cnt    = (m_pkt_cnt + 1) % 65536;
          m_flush_left = CLR;
        end
      end else if (m_scanning) begin
        if (rise) begin
          m_data  = buf_dout;
          m_phase = (pos >= PO);
          m_valid = 1'b1;
        end else if (!en) begin
          m_scanning = 1'b0;
        end
      end else if (m_flush_left > 0) begin
        m_flush_left--;
        if (m_flush_left == 0 && en) begin
          m_scanning = 1'b1;
          m_origin   = cyc + 1;
        end
      end else if (en) begin
        m_flush_left = CLR;
      end
      m_prev_rec = buf_pkt_rec;
    end
    cyc      = cyc + 1;
    model_ok = 1'b1;
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    int pos;
    if (model_ok) begin
      pos = (cyc - m_origin) % BP;
      checkOutput("sh_en2",    sh_en2,    m_scanning && pos == 0);
      checkOutput("sh_en1",    sh_en1,    m_scanning && pos == PO);
      checkOutput("strobe_excl", sh_en1 & sh_en2, 0);
      checkOutput("buf_clr",   buf_clr,   m_flush_left > 0);
      checkOutput("pkt_valid", pkt_valid, m_valid);
      checkOutput("pkt_data",  pkt_data,  m_data);
      checkOutput("pkt_phase", pkt_phase, m_phase);
      checkOutput("pkt_cnt",   pkt_cnt,   64'(m_pkt_cnt));
      checkOutput("drop_cnt",  drop_cnt,  64'(m_drop));
    end
  end

  initial begin
    #200000;
    fails++;
    $display("[TB] FAIL watchdog at cycle %0d: actual running expected finished", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int silent;
    rst = 1'b1; en = 1'b0; buf_pkt_rec = 1'b0; buf_dout = '0; pkt_ready = 1'b0;

    // Scenario 1: reset, enable, flush then strobes
    applyStimulus(1, 0, 0, '0, 0);
    applyStimulus(1, 0, 0, '0, 0);
    checkOutput("reset_valid", pkt_valid, 0);
    checkOutput("reset_clr",   buf_clr,   0);
    checkOutput("reset_cnt",   pkt_cnt,   0);
    applyStimulus(0, 1, 0, '0, 0);
    checkOutput("s1_clr_c4", buf_clr, 1);
    applyStimulus(0, 1, 0, '0, 0);
    checkOutput("s1_clr_c5", buf_clr, 1);
    applyStimulus(0, 1, 0, '0, 0);
    checkOutput("s1_sh_en2_c6", sh_en2, 1);
    checkOutput("s1_clr_c6", buf_clr, 0);
    repeat (5) applyStimulus(0, 1, 0, '0, 0);
    checkOutput("s1_sh_en1_c11", sh_en1, 1);
    repeat (2) applyStimulus(0, 1, 0, '0, 0);

    // Scenario 2: capture in the late half, immediate accept
    applyStimulus(0, 1, 1, WORD_A, 0);
    checkOutput("s2_valid", pkt_valid, 1);
    checkOutput("s2_data",  pkt_data,  WORD_A);
    checkOutput("s2_phase", pkt_phase, 1);
    applyStimulus(0, 1, 0, WORD_A, 1);
    checkOutput("s2_valid_drop", pkt_valid, 0);
    checkOutput("s2_pkt_cnt",    pkt_cnt,   1);
    checkOutput("s2_clr_c15",    buf_clr,   1);
    applyStimulus(0, 1, 0, '0, 0);
    checkOutput("s2_clr_c16", buf_clr, 1);
    applyStimulus(0, 1, 0, '0, 0);
    checkOutput("s2_sh_en2_c17", sh_en2, 1);
    repeat (3) applyStimulus(0, 1, 0, '0, 0);

    // Scenario 3: stalled delivery with three dropped packets
    applyStimulus(0, 1, 1, WORD_B, 0);
    checkOutput("s3_valid", pkt_valid, 1);
    checkOutput("s3_phase", pkt_phase, 0);
    for (int i = 0; i < 40; i++) begin
      applyStimulus(0, 1, (i == 5 || i == 15 || i == 25), 64'(i) * 64'h0101_0101_0101_0101, 0);
    end
    checkOutput("s3_data_held", pkt_data, WORD_B);
    checkOutput("s3_drops",     drop_cnt, 3);
    applyStimulus(0, 1, 0, '0, 1);
    checkOutput("s3_pkt_cnt", pkt_cnt, 2);
    applyStimulus(0, 1, 0, '0, 1);
    checkOutput("s3_single_accept", pkt_cnt, 2);
    applyStimulus(0, 1, 0, '0, 0);

    // Scenario 4: drop counter saturation
    applyStimulus(0, 1, 1, WORD_C, 0);
    for (int i = 0; i < 600; i++) begin
      applyStimulus(0, 1, (i % 2 == 1), '0, 0);
    end
    checkOutput("s4_drop_sat", drop_cnt, 255);
    checkOutput("s4_data",     pkt_data, WORD_C);
    applyStimulus(0, 1, 0, '0, 1);
    checkOutput("s4_pkt_cnt", pkt_cnt, 3);
    repeat (5) applyStimulus(0, 1, 0, '0, 0);

    // Scenario 5: rise wins over en=0, then flush and go idle
    applyStimulus(0, 0, 1, WORD_D, 0);
    checkOutput("s5_valid", pkt_valid, 1);
    checkOutput("s5_data",  pkt_data,  WORD_D);
    applyStimulus(0, 0, 0, '0, 1);
    checkOutput("s5_pkt_cnt", pkt_cnt, 4);
    checkOutput("s5_clr_1",   buf_clr, 1);
    applyStimulus(0, 0, 0, '0, 0);
    checkOutput("s5_clr_2", buf_clr, 1);
    silent = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 0, '0, 0);
      if (sh_en1 || sh_en2 || buf_clr) silent++;
    end
    checkOutput("s5_idle_silent", silent, 0);

    // Scenario 6: reset during a pending delivery, then re-enable
    repeat (5) applyStimulus(0, 1, 0, '0, 0);
    applyStimulus(0, 1, 1, WORD_E, 0);
    checkOutput("s6_valid", pkt_valid, 1);
    applyStimulus(0, 1, 0, WORD_E, 0);
    applyStimulus(0, 1, 0, WORD_E, 0);
    applyStimulus(1, 0, 0, '0, 0);
    checkOutput("s6_rst_valid", pkt_valid, 0);
    checkOutput("s6_rst_data",  pkt_data,  0);
    checkOutput("s6_rst_cnt",   pkt_cnt,   0);
    checkOutput("s6_rst_drop",  drop_cnt,  0);
    checkOutput("s6_rst_phase", pkt_phase, 0);
    for (int k = 1; k <= 25; k++) begin
      applyStimulus(0, 1, 0, '0, 0);
      checkOutput("s6_clr",    buf_clr, (k + 1 == 2 || k + 1 == 3));
      checkOutput("s6_sh_en2", sh_en2,  (k + 1 == 4 || k + 1 == 14 || k + 1 == 24));
      checkOutput("s6_sh_en1", sh_en1,  (k + 1 == 9 || k + 1 == 19));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
